uart_rx_frame: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_frame_if.sv | 36 +++
 rtl/uart_rx_sampler.sv | 67 ++++++
 rtl/uart_rx_frame.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART constants and types for the transmit and receive sides.
//   UART_CLKS_PER_BIT : clocks per serial bit cell
//   UART_DATA_BITS    : data bits per frame
//   rx_state_t        : receive framing FSM states
//   maj3()            : 2-of-3 majority vote helper
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // 2-of-3 majority of three line samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_if
// Consumer-side bundle of the UART receiver.
//   rx_dataH   : last accepted byte              (receiver -> consumer)
//   rx_validH  : rx_dataH holds an unconsumed byte (receiver -> consumer)
//   frame_errH : sticky framing error            (receiver -> consumer)
//   overrunH   : sticky overrun                  (receiver -> consumer)
//   busyH      : receiver is inside a frame      (receiver -> consumer)
//   rx_ackH    : consumer takes the byte         (consumer -> receiver)
//   clr_errH   : clear both sticky flags         (consumer -> receiver)
// master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface uart_rx_frame_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);
    logic [DATA_BITS-1:0] rx_dataH;
    logic                 rx_validH;
    logic                 frame_errH;
    logic                 overrunH;
    logic                 busyH;
    logic                 rx_ackH;
    logic                 clr_errH;

    modport master (
        output rx_dataH, rx_validH, frame_errH, overrunH, busyH,
        input  rx_ackH, clr_errH
    );

    modport slave (
        input  rx_dataH, rx_validH, frame_errH, overrunH, busyH,
        output rx_ackH, clr_errH
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Line conditioning for the UART receiver: 2-flop synchronizer, one-flop
// history for falling-edge detection and a 3-sample majority vote around the
// bit-cell centre.
//   sys_clk, sys_rst_l : clock, async active-low reset
//   uart_dataH         : raw serial line (asynchronous, idle high)
//   cntr               : bit-cell counter from the framing FSM
//   fall_detH          : synced line went 1 -> 0 this cycle
//   bit_valH           : majority of samples at cntr = M-1, M, M+1
//                        (valid while cntr = M+1)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_l,
    input  logic                            uart_dataH,
    input  logic [$clog2(CLKS_PER_BIT)-1:0] cntr,
    output logic                            fall_detH,
    output logic                            bit_valH
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] SAMP_A = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] SAMP_B = CNT_W'(CLKS_PER_BIT / 2);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic samp_a_r;
    logic samp_b_r;

    // Synchronizer plus history flop; all reset to the idle (high) level
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= uart_dataH;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Capture the first two votes; the third is the live synced value
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            samp_a_r <= 1'b1;
            samp_b_r <= 1'b1;
        end else begin
            if (cntr == SAMP_A) begin
                samp_a_r <= sync2_r;
            end
            if (cntr == SAMP_B) begin
                samp_b_r <= sync2_r;
            end
        end
    end

    assign fall_detH = prev_r & ~sync2_r;
    assign bit_valH  = maj3(samp_a_r, samp_b_r, sync2_r);

endmodule

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
// UART receive front-end: 1 start, DATA_BITS data (LSB first), 1 stop bit.
// Majority-vote sampling, false-start rejection, framing-error and overrun
// detection, valid/ack handshake toward the consumer.
//   sys_clk, sys_rst_l : clock, async active-low reset
//   uart_dataH         : serial line, idle high, asynchronous
//   rx (master)        : rx_dataH, rx_validH, frame_errH, overrunH, busyH out;
//                        rx_ackH, clr_errH in
// All outputs are registered.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic            sys_clk,
    input  logic            sys_rst_l,
    input  logic            uart_dataH,
    uart_rx_frame_if.master rx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] DEC_CNT  = CNT_W'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_t            state_r;
    rx_state_t            state_n;
    logic [CNT_W-1:0]     cntr_r;
    logic [CNT_W-1:0]     cntr_n;
    logic [IDX_W-1:0]     bit_idx_r;
    logic [IDX_W-1:0]     bit_idx_n;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_n;

    logic                 fall_det_s;
    logic                 bit_val_s;
    logic                 decide_s;
    logic                 last_s;
    logic                 deliver_s;
    logic                 stop_bad_s;

    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic                 frame_err_r;
    logic                 overrun_r;
    logic                 busy_r;

    uart_rx_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_sampler (
        .sys_clk    (sys_clk),
        .sys_rst_l  (sys_rst_l),
        .uart_dataH (uart_dataH),
        .cntr       (cntr_r),
        .fall_detH  (fall_det_s),
        .bit_valH   (bit_val_s)
    );

    assign decide_s = (cntr_r == DEC_CNT);
    assign last_s   = (cntr_r == LAST_CNT);

    // Framing FSM state, bit-cell counter, bit index and shift register
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_r   <= IDLE;
            cntr_r    <= '0;
            bit_idx_r <= '0;
            shift_r   <= '0;
        end else begin
            state_r   <= state_n;
            cntr_r    <= cntr_n;
            bit_idx_r <= bit_idx_n;
            shift_r   <= shift_n;
        end
    end

    // Next-state logic and per-frame delivery strobes
    always_comb begin
        state_n    = state_r;
        cntr_n     = cntr_r;
        bit_idx_n  = bit_idx_r;
        shift_n    = shift_r;
        deliver_s  = 1'b0;
        stop_bad_s = 1'b0;
        case (state_r)
            IDLE: begin
                cntr_n    = '0;
                bit_idx_n = '0;
                if (fall_det_s) begin
                    state_n = START;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (decide_s && bit_val_s) begin
                    // line back high at the cell centre: glitch, not a start bit
                    state_n = IDLE;
                    cntr_n  = '0;
                end else if (last_s) begin
                    state_n   = DATA;
                    cntr_n    = '0;
                    bit_idx_n = '0;
                end else begin
                    cntr_n = cntr_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (decide_s) begin
                    // shift right so the first received bit ends up in bit 0
                    shift_n = {bit_val_s, shift_r[DATA_BITS-1:1]};
                end else begin
                    shift_n = shift_r;
                end
                if (last_s) begin
                    cntr_n = '0;
                    if (bit_idx_r == LAST_IDX) begin
                        state_n   = STOP;
                        bit_idx_n = '0;
                    end else begin
                        bit_idx_n = bit_idx_r + IDX_W'(1);
                    end
                end else begin
                    cntr_n = cntr_r + CNT_W'(1);
                end
            end
            STOP: begin
                // leave at the centre so a next start bit half a cell later is seen
                if (decide_s) begin
                    state_n = IDLE;
                    cntr_n  = '0;
                    if (bit_val_s) begin
                        deliver_s = 1'b1;
                    end else begin
                        stop_bad_s = 1'b1;
                    end
                end else begin
                    cntr_n = cntr_r + CNT_W'(1);
                end
            end
            default: begin
                state_n   = IDLE;
                cntr_n    = '0;
                bit_idx_n = '0;
            end
        endcase
    end

    // Output register, handshake and sticky flags (set beats clear)
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            busy_r <= (state_n != IDLE);

            if (deliver_s && (!rx_valid_r || rx.rx_ackH)) begin
                rx_data_r  <= shift_r;
                rx_valid_r <= 1'b1;
            end else if (rx.rx_ackH) begin
                rx_valid_r <= 1'b0;
            end

            if (stop_bad_s) begin
                frame_err_r <= 1'b1;
            end else if (rx.clr_errH) begin
                frame_err_r <= 1'b0;
            end

            if (deliver_s && rx_valid_r && !rx.rx_ackH) begin
                overrun_r <= 1'b1;
            end else if (rx.clr_errH) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign rx.rx_dataH   = rx_data_r;
    assign rx.rx_validH  = rx_valid_r;
    assign rx.frame_errH = frame_err_r;
    assign rx.overrunH   = overrun_r;
    assign rx.busyH      = busy_r;

endmodule
